// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the bit-serial ALU: ctrl_i operation
//             encodings, FSM state type, per-slice operation select and the
//             decoded control word with its decode helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // ctrl_i operation encodings
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Function applied inside one slice after the optional operand inversions
  typedef enum logic [1:0] {
    SOP_ZERO = 2'd0,
    SOP_AND  = 2'd1,
    SOP_OR   = 2'd2,
    SOP_ADD  = 2'd3
  } slice_op_e;

  typedef struct packed {
    slice_op_e op;
    logic      a_inv;
    logic      b_inv;
    logic      arith;   // carry out of the MSB is reported
    logic      slt;     // final result replaced by the signed less-than bit
  } ctrl_dec_t;

  // Undefined codes fall through to SOP_ZERO with no arithmetic flags,
  // which yields result 0 / zero 1 / cout 0 at normal latency.
  function automatic ctrl_dec_t decode_ctrl(input logic [3:0] ctrl);
    ctrl_dec_t d;
    d.op    = SOP_ZERO;
    d.a_inv = 1'b0;
    d.b_inv = 1'b0;
    d.arith = 1'b0;
    d.slt   = 1'b0;
    case (ctrl)
      CTRL_AND: d.op = SOP_AND;
      CTRL_OR:  d.op = SOP_OR;
      CTRL_ADD: begin
        d.op    = SOP_ADD;
        d.arith = 1'b1;
      end
      CTRL_SUB: begin
        d.op    = SOP_ADD;
        d.b_inv = 1'b1;
        d.arith = 1'b1;
      end
      CTRL_SLT: begin
        d.op    = SOP_ADD;
        d.b_inv = 1'b1;
        d.arith = 1'b1;
        d.slt   = 1'b1;
      end
      CTRL_NOR: begin
        d.op    = SOP_AND;
        d.a_inv = 1'b1;
        d.b_inv = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  // Two's-complement subtraction starts with carry 1 (a + ~b + 1)
  function automatic logic carry_init(input logic [3:0] ctrl);
    return (ctrl == CTRL_SUB) || (ctrl == CTRL_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
//  Module   : alu_slice
//  Purpose  : Combinational SLICE-bit ALU slice used once per cycle by
//             alu_serial. Optionally inverts A and/or B, then applies AND,
//             OR or ADD (with carry-in), or drives zero.
//  Ports    : a_i, b_i      SLICE-bit operand slices
//             a_inv_i       invert A before the operation
//             b_inv_i       invert B before the operation
//             op_i          slice function select
//             cin_i         carry into bit 0 of the slice
//             res_o         slice result
//             cout_o        carry out of the slice MSB
//             msb_cin_o     carry into the slice MSB (for signed overflow)
//  Revision : 1.0  initial release
// ============================================================================
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             a_inv_i,
  input  logic             b_inv_i,
  input  slice_op_e        op_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] res_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  logic [SLICE-1:0] a_w;
  logic [SLICE-1:0] b_w;
  logic [SLICE:0]   sum_w;

  always_comb begin
    a_w   = a_inv_i ? ~a_i : a_i;
    b_w   = b_inv_i ? ~b_i : b_i;
    sum_w = {1'b0, a_w} + {1'b0, b_w} + {{SLICE{1'b0}}, cin_i};
  end

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c
  assign cout_o    = sum_w[SLICE];
  assign msb_cin_o = a_w[SLICE-1] ^ b_w[SLICE-1] ^ sum_w[SLICE-1];

  always_comb begin
    res_o = '0;
    case (op_i)
      SOP_AND: res_o = a_w & b_w;
      SOP_OR:  res_o = a_w | b_w;
      SOP_ADD: res_o = sum_w[SLICE-1:0];
      default: res_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial
//  Purpose  : Bit-serial ALU. Operands are latched on accept and processed
//             SLICE bits per cycle, LSB slice first, through one alu_slice.
//             Result and flags are committed together when the last slice
//             completes and are held until the next accept.
//  Params   : WIDTH  operand/result width (multiple of SLICE)
//             SLICE  bits processed per cycle
//  Ports    : clk_i       clock, rising edge
//             rst_i       asynchronous reset, active low
//             start_i     request, accepted while ready_o = 1
//             ctrl_i      operation code (see alu_pkg)
//             src1_i      operand A, sampled at accept
//             src2_i      operand B, sampled at accept
//             ready_o     idle, start_i will be accepted
//             valid_o     one-cycle pulse when result/flags are fresh
//             result_o    result
//             zero_o      result_o == 0
//             cout_o      carry out of MSB for ADD/SUB/SLT, else 0
//             overflow_o  signed overflow of ADD/SUB (only with macro
//                         ALU_SERIAL_OVF_EN defined)
//  Config   : `define ALU_SERIAL_OVF_EN to add the overflow_o port
//  Revision : 1.0  initial release
// ============================================================================
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_cfg
      $error("alu_serial: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  ctrl_dec_t        dec_w;
  logic [SLICE-1:0] slice_res_w;
  logic             slice_cout_w;
  logic             slice_msb_cin_w;
  logic             last_w;
  logic [WIDTH-1:0] acc_next_w;
  logic             ovf_w;
  logic             less_w;
  logic [WIDTH-1:0] res_final_w;

  assign dec_w  = decode_ctrl(ctrl_q);
  assign last_w = (cnt_q == CNT_LAST);

  // Operands are shifted right each RUN cycle, so slice k is always bits
  // [SLICE-1:0] of the shift registers.
  alu_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i       (a_q[SLICE-1:0]),
    .b_i       (b_q[SLICE-1:0]),
    .a_inv_i   (dec_w.a_inv),
    .b_inv_i   (dec_w.b_inv),
    .op_i      (dec_w.op),
    .cin_i     (carry_q),
    .res_o     (slice_res_w),
    .cout_o    (slice_cout_w),
    .msb_cin_o (slice_msb_cin_w)
  );

  // Slice results enter the accumulator at the top and shift down, so after
  // NSLICE cycles slice 0 sits in the LSBs.
  always_comb begin
    acc_next_w  = (acc_q >> SLICE) | (WIDTH'(slice_res_w) << (WIDTH - SLICE));
    // Meaningful only while the last slice is processed
    ovf_w       = slice_msb_cin_w ^ slice_cout_w;
    less_w      = acc_next_w[WIDTH-1] ^ ovf_w;
    res_final_w = dec_w.slt ? WIDTH'(less_w) : acc_next_w;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (last_w)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_DONE: valid_o = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
`ifdef ALU_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = src1_i;
          b_d     = src2_i;
          ctrl_d  = ctrl_i;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = carry_init(ctrl_i);
        end
      end
      ST_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        acc_d   = acc_next_w;
        carry_d = slice_cout_w;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_w) begin
          result_d = res_final_w;
          zero_d   = (res_final_w == '0);
          cout_d   = dec_w.arith & slice_cout_w;
`ifdef ALU_SERIAL_OVF_EN
          ovf_d    = ((ctrl_q == CTRL_ADD) || (ctrl_q == CTRL_SUB)) & ovf_w;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign cout_o   = cout_q;
`ifdef ALU_SERIAL_OVF_EN
  assign overflow_o = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_serial
//  Purpose  : Self-checking bench for alu_serial. Four instances (SLICE = 4,
//             1, 8, 32; WIDTH = 32) share one stimulus stream; each has its
//             own arithmetic reference model and per-cycle compare process.
//             Directed operations pin known values on the SLICE = 4 instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_serial;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int ND = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    ctrl  = 4'd0;
  logic [W-1:0]  src1  = '0;
  logic [W-1:0]  src2  = '0;

  logic [ND-1:0] rdy, vld, zr, co;
  logic [W-1:0]  res [ND];
`ifdef ALU_SERIAL_OVF_EN
  logic [ND-1:0] ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on the whole operands
  function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic cy, output logic ov);
    longint sa, sb, x;
    logic [32:0] s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; cy = 1'b0; ov = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        x  = sa + sb;
        ov = (x > 64'sd2147483647) || (x < -64'sd2147483648);
      end
      4'b0110: begin
        r  = a - b;
        cy = (a >= b);
        x  = sa - sb;
        ov = (x > 64'sd2147483647) || (x < -64'sd2147483648);
      end
      4'b0111: begin
        r  = (sa < sb) ? 32'd1 : 32'd0;
        cy = (a >= b);
      end
      4'b1100: r = ~(a | b);
      default: ;
    endcase
  endfunction

  function automatic logic [3:0] pick_ctrl();
    case ($urandom_range(0, 6))
      0: return CTRL_AND;
      1: return CTRL_OR;
      2: return CTRL_ADD;
      3: return CTRL_SUB;
      4: return CTRL_SLT;
      5: return CTRL_NOR;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int SL = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
      localparam int NS = W / SL;

      alu_serial #(
        .WIDTH (W),
        .SLICE (SL)
      ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .ctrl_i     (ctrl),
        .src1_i     (src1),
        .src2_i     (src2),
        .ready_o    (rdy[g]),
        .valid_o    (vld[g]),
        .result_o   (res[g]),
        .zero_o     (zr[g]),
        .cout_o     (co[g])
`ifdef ALU_SERIAL_OVF_EN
        ,
        .overflow_o (ovf[g])
`endif
      );

      // Model: cnt = cycles left until idle; cnt == 1 is the result cycle
      initial begin
        int          cnt;
        logic [31:0] m_res, p_res;
        logic        m_zero, m_co, m_ov, p_co, p_ov;
        string       tag;
        cnt = 0; m_res = '0; m_zero = 1'b1; m_co = 1'b0; m_ov = 1'b0;
        p_res = '0; p_co = 1'b0; p_ov = 1'b0;
        tag = $sformatf("slice%0d", SL);
        forever begin
          @(posedge clk);
          if (!rst_n) begin
            cnt = 0; m_res = '0; m_zero = 1'b1; m_co = 1'b0; m_ov = 1'b0;
          end else if (cnt > 0) begin
            cnt--;
            if (cnt == 1) begin
              m_res  = p_res;
              m_zero = (p_res == 32'd0);
              m_co   = p_co;
              m_ov   = p_ov;
            end
          end else if (start) begin
            ref_op(ctrl, src1, src2, p_res, p_co, p_ov);
            cnt = NS + 1;
          end
          #1;
          chk({tag, " ready"},  32'(rdy[g]), 32'(cnt == 0));
          chk({tag, " valid"},  32'(vld[g]), 32'(cnt == 1));
          chk({tag, " result"}, res[g], m_res);
          chk({tag, " zero"},   32'(zr[g]), 32'(m_zero));
          chk({tag, " cout"},   32'(co[g]), 32'(m_co));
`ifdef ALU_SERIAL_OVF_EN
          chk({tag, " ovf"},    32'(ovf[g]), 32'(m_ov));
`endif
        end
      end
    end
  endgenerate

  // Present an op at the current negedge for one cycle, then scramble inputs
  // so anything sampled after accept would corrupt the result.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; ctrl = c; src1 = a; src2 = b;
    @(negedge clk);
    start = 1'b0; ctrl = 4'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rdy != {ND{1'b1}} && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("all idle", 32'(rdy), 32'({ND{1'b1}}));
  endtask

  // Directed op on the SLICE=4 instance with literal expectations
  task automatic op0(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e_res, input logic e_zero, input logic e_co, input logic e_ov);
    int lat;
    issue(c, a, b);
    lat = 1;
    while (!vld[0] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 32'd9);
    chk({nm, " result"}, res[0], e_res);
    chk({nm, " zero"}, 32'(zr[0]), 32'(e_zero));
    chk({nm, " cout"}, 32'(co[0]), 32'(e_co));
`ifdef ALU_SERIAL_OVF_EN
    chk({nm, " ovf"}, 32'(ovf[0]), 32'(e_ov));
`else
    if (e_ov === 1'bx) $display("note: unexpected x");
`endif
    wait_idle();
  endtask

  initial begin
    int t, t1, t2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready",  32'(rdy[0]), 32'd1);
    chk("reset valid",  32'(vld), 32'd0);
    chk("reset result", res[0], 32'd0);
    chk("reset zero",   32'(zr[0]), 32'd1);
    chk("reset cout",   32'(co[0]), 32'd0);

    // First op presented in the same cycle reset releases
    rst_n = 1'b1;
    op0("add ovf", CTRL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    op0("sub eq",  CTRL_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0);
    op0("slt neg", CTRL_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1'b0, 1'b1, 1'b0);
    op0("slt pos", CTRL_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    // ~(F0F0F0F0 | 0F0F0F00) = ~FFFFFFF0
    op0("nor",     CTRL_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    op0("and",     CTRL_AND, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    op0("or",      CTRL_OR,  32'hF0F0_F0F0, 32'h0F0F_0F00, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    op0("undef",   4'b1111,  32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0, 1'b0);
    op0("sub ovf", CTRL_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

    // start held high with operands changing every cycle
    t = 0; t1 = -1; t2 = -1;
    start = 1'b1;
    while (t2 < 0 && t < 100) begin
      ctrl = pick_ctrl(); src1 = pick_opnd(); src2 = pick_opnd();
      @(negedge clk);
      t++;
      if (vld[0]) begin
        if (t1 < 0) t1 = t;
        else t2 = t;
      end
    end
    chk("held interval", t2 - t1, 32'd10);
    start = 1'b0;
    wait_idle();

    // Reset during the third RUN cycle
    issue(CTRL_ADD, $urandom, $urandom);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort ready",  32'(rdy[0]), 32'd1);
    chk("abort valid",  32'(vld), 32'd0);
    chk("abort result", res[0], 32'd0);
    chk("abort zero",   32'(zr[0]), 32'd1);
    chk("abort cout",   32'(co[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op0("post reset", CTRL_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);

    // Random ops, checked per cycle by each instance's model
    repeat (150) begin
      issue(pick_ctrl(), pick_opnd(), pick_opnd());
      wait_idle();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
